// File: rtl/stream_mux_2x1.sv
// stream_mux_2x1: merges two valid/ready source channels onto one registered
// output channel. Sources are picked round-robin. Once a packet starts, the
// mux stays on that source until the word flagged last has been transferred.
// Each output word carries dout_sel, the index of the source it came from.
module stream_mux_2x1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din0,
  input  logic             din0_valid,
  input  logic             din0_last,
  output logic             din0_ready,
  input  logic [WIDTH-1:0] din1,
  input  logic             din1_valid,
  input  logic             din1_last,
  output logic             din1_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             dout_sel,
  input  logic             dout_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_last_q, dout_last_d;
  logic             dout_sel_q, dout_sel_d;

  logic             grant_vld;
  logic             grant_idx;
  logic             can_load;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             xfer;

  // Arbitration: pick the granted source from the FSM state and the valids.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din0_valid && din1_valid) begin
          grant_vld = 1'b1;
          grant_idx = ptr_q;
        end else if (din0_valid) begin
          grant_vld = 1'b1;
          grant_idx = 1'b0;
        end else if (din1_valid) begin
          grant_vld = 1'b1;
          grant_idx = 1'b1;
        end
      end
      LOCK0: begin
        grant_vld = 1'b1;
        grant_idx = 1'b0;
      end
      LOCK1: begin
        grant_vld = 1'b1;
        grant_idx = 1'b1;
      end
      default: begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
      end
    endcase
  end

  // Readies and transfer detection for the granted channel.
  always_comb begin
    can_load   = !dout_valid_q || dout_ready;
    sel_valid  = grant_idx ? din1_valid : din0_valid;
    sel_last   = grant_idx ? din1_last  : din0_last;
    sel_data   = grant_idx ? din1       : din0;
    xfer       = can_load && grant_vld && sel_valid;
    din0_ready = can_load && grant_vld && !grant_idx && rst_n;
    din1_ready = can_load && grant_vld &&  grant_idx && rst_n;
  end

  // Next-state logic: load the output register, update the lock and the pointer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dout_sel_d   = dout_sel_q;
    if (xfer) begin
      dout_d       = sel_data;
      dout_last_d  = sel_last;
      dout_sel_d   = grant_idx;
      dout_valid_d = 1'b1;
      if (sel_last) begin
        state_d = IDLE;
        ptr_d   = ~grant_idx;
      end else begin
        state_d = grant_idx ? LOCK1 : LOCK0;
      end
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_sel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_sel_q   <= dout_sel_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout_sel   = dout_sel_q;

endmodule

// File: tb/tb_stream_mux_2x1.sv
// Directed testbench for stream_mux_2x1: one task per scenario, each with its
// own inline comparisons against hand-computed values.
module tb_stream_mux_2x1;

  logic       clk;
  logic       rst_n;
  logic [7:0] din0, din1, dout;
  logic       din0_valid, din0_last, din0_ready;
  logic       din1_valid, din1_last, din1_ready;
  logic       dout_valid, dout_last, dout_sel, dout_ready;

  int checks;
  int failures;

  stream_mux_2x1 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din0       (din0),
    .din0_valid (din0_valid),
    .din0_last  (din0_last),
    .din0_ready (din0_ready),
    .din1       (din1),
    .din1_valid (din1_valid),
    .din1_last  (din1_last),
    .din1_ready (din1_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_sel   (dout_sel),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    din0       = 8'h00;
    din1       = 8'h00;
    din0_valid = 1'b0;
    din1_valid = 1'b0;
    din0_last  = 1'b0;
    din1_last  = 1'b0;
    dout_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    din0_valid = 1'b1;
    din1_valid = 1'b1;
    dout_ready = 1'b1;
    repeat (2) step();
    checks++;
    if ({dout_valid, dout_last, dout_sel} !== 3'b000 || dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_out: got v=%b l=%b s=%b d=%h want 0 0 0 00", dout_valid, dout_last, dout_sel, dout);
    end
    checks++;
    if ({din0_ready, din1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b%b want 00", din0_ready, din1_ready);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    din0 = 8'h5A; din0_last = 1'b1; din0_valid = 1'b1; dout_ready = 1'b1;
    #1;
    checks++;
    if ({din0_ready, din1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL single_ready: got %b%b want 10", din0_ready, din1_ready);
    end
    step();
    din0_valid = 1'b0;
    checks++;
    if (dout !== 8'h5A || dout_sel !== 1'b0 || dout_last !== 1'b1 || dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_out: got d=%h s=%b l=%b v=%b want 5a 0 1 1", dout, dout_sel, dout_last, dout_valid);
    end
    step();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: got v=%b want 0", dout_valid);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] exp_d;
    logic       exp_s;
    do_reset();
    din0 = 8'h11; din1 = 8'h22; din0_last = 1'b1; din1_last = 1'b1;
    din0_valid = 1'b1; din1_valid = 1'b1; dout_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_s = (i % 2 == 1);
      exp_d = exp_s ? 8'h22 : 8'h11;
      checks++;
      if ({din0_ready, din1_ready} !== {~exp_s, exp_s}) begin
        failures++;
        $display("FAIL alt_ready[%0d]: got %b%b want %b%b", i, din0_ready, din1_ready, ~exp_s, exp_s);
      end
      step();
      checks++;
      if (dout !== exp_d || dout_sel !== exp_s || dout_valid !== 1'b1) begin
        failures++;
        $display("FAIL alt_out[%0d]: got d=%h s=%b v=%b want %h %b 1", i, dout, dout_sel, dout_valid, exp_d, exp_s);
      end
    end
    din0_valid = 1'b0; din1_valid = 1'b0;
  endtask

  task automatic test_packet();
    logic [7:0] pkt [3];
    pkt[0] = 8'hA1; pkt[1] = 8'hA2; pkt[2] = 8'hA3;
    do_reset();
    dout_ready = 1'b1;
    // single word from channel 0 moves the pointer to channel 1
    din0 = 8'h55; din0_last = 1'b1; din0_valid = 1'b1;
    din1 = pkt[0]; din1_last = 1'b0; din1_valid = 1'b1;
    step();
    din0 = 8'h66;
    for (int i = 0; i < 3; i++) begin
      din1 = pkt[i]; din1_last = (i == 2);
      #1;
      checks++;
      if ({din0_ready, din1_ready} !== 2'b01) begin
        failures++;
        $display("FAIL pkt_ready[%0d]: got %b%b want 01", i, din0_ready, din1_ready);
      end
      step();
      checks++;
      if (dout !== pkt[i] || dout_sel !== 1'b1 || dout_last !== (i == 2)) begin
        failures++;
        $display("FAIL pkt_out[%0d]: got d=%h s=%b l=%b want %h 1 %b", i, dout, dout_sel, dout_last, pkt[i], (i == 2));
      end
    end
    din1_valid = 1'b0;
    #1;
    checks++;
    if ({din0_ready, din1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL pkt_after_ready: got %b%b want 10", din0_ready, din1_ready);
    end
    step();
    din0_valid = 1'b0;
    checks++;
    if (dout !== 8'h66 || dout_sel !== 1'b0) begin
      failures++;
      $display("FAIL pkt_after_out: got d=%h s=%b want 66 0", dout, dout_sel);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dout_ready = 1'b0;
    din0 = 8'h33; din0_last = 1'b1; din0_valid = 1'b1;
    step();
    din0 = 8'h44;
    din1 = 8'h22; din1_last = 1'b1; din1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({din0_ready, din1_ready} !== 2'b00 || dout !== 8'h33 || dout_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got r=%b%b d=%h v=%b want r=00 d=33 v=1", i, din0_ready, din1_ready, dout, dout_valid);
      end
      step();
    end
    dout_ready = 1'b1;
    #1;
    checks++;
    if ({din0_ready, din1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release_ready: got %b%b want 01", din0_ready, din1_ready);
    end
    step();
    din0_valid = 1'b0; din1_valid = 1'b0;
    checks++;
    if (dout !== 8'h22 || dout_sel !== 1'b1 || dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_out: got d=%h s=%b v=%b want 22 1 1", dout, dout_sel, dout_valid);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    dout_ready = 1'b1;
    din0_valid = 1'b1; din0_last = 1'b0;
    din0 = 8'h01; step();
    din0 = 8'h02; step();
    din0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h00 || {din0_ready, din1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid: got v=%b d=%h r=%b%b want 0 00 00", dout_valid, dout, din0_ready, din1_ready);
    end
    step();
    rst_n = 1'b1;
    din0 = 8'h03; din0_last = 1'b1; din0_valid = 1'b1;
    din1 = 8'hB1; din1_last = 1'b1; din1_valid = 1'b1;
    #1;
    checks++;
    if ({din0_ready, din1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL rst_ptr: got %b%b want 10", din0_ready, din1_ready);
    end
    din0_valid = 1'b0;
    #1;
    checks++;
    if ({din0_ready, din1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rst_stale_lock: got %b%b want 01", din0_ready, din1_ready);
    end
    step();
    din1_valid = 1'b0;
    checks++;
    if (dout !== 8'hB1 || dout_sel !== 1'b1) begin
      failures++;
      $display("FAIL rst_after_out: got d=%h s=%b want b1 1", dout, dout_sel);
    end
  endtask

  task automatic test_lock_stall();
    do_reset();
    dout_ready = 1'b1;
    din0 = 8'h0A; din0_last = 1'b0; din0_valid = 1'b1;
    step();
    din0_valid = 1'b0;
    din1 = 8'hC1; din1_last = 1'b1; din1_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (din1_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready1[%0d]: got %b want 0", i, din1_ready);
      end
      step();
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drained: got v=%b want 0", dout_valid);
    end
    din0 = 8'h0B; din0_last = 1'b1; din0_valid = 1'b1;
    #1;
    checks++;
    if ({din0_ready, din1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL stall_resume_ready: got %b%b want 10", din0_ready, din1_ready);
    end
    step();
    din0_valid = 1'b0;
    checks++;
    if (dout !== 8'h0B || dout_sel !== 1'b0 || dout_last !== 1'b1) begin
      failures++;
      $display("FAIL stall_resume_out: got d=%h s=%b l=%b want 0b 0 1", dout, dout_sel, dout_last);
    end
    #1;
    checks++;
    if ({din0_ready, din1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL stall_next_ready: got %b%b want 01", din0_ready, din1_ready);
    end
    step();
    din1_valid = 1'b0;
    checks++;
    if (dout !== 8'hC1 || dout_sel !== 1'b1) begin
      failures++;
      $display("FAIL stall_next_out: got d=%h s=%b want c1 1", dout, dout_sel);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n      = 1'b0;
    din0       = 8'h00;
    din1       = 8'h00;
    din0_valid = 1'b0;
    din1_valid = 1'b0;
    din0_last  = 1'b0;
    din1_last  = 1'b0;
    dout_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_alternate();
    test_packet();
    test_backpressure();
    test_reset_mid_packet();
    test_lock_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_2x1.md
Name: stream_mux_2x1

Overview:
- Two-input to one-output stream merger; the return-path counterpart of the 1x2 demux.
- Accepts words from two valid/ready source channels and arbitrates between them round-robin, with packet locking on a last flag.
- Drives one registered output channel, tagged with the source index (dout_sel) so a downstream 1x2 demux can route the word back.
- Sits between two producers and a shared consumer/link.

Parameters:
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din0  input  WIDTH  channel 0 data.
- din0_valid  input  1  channel 0 word present.
- din0_last  input  1  channel 0 word is last of packet.
- din0_ready  output  1  channel 0 word accepted this cycle when high with din0_valid.
- din1  input  WIDTH  channel 1 data.
- din1_valid  input  1  channel 1 word present.
- din1_last  input  1  channel 1 word is last of packet.
- din1_ready  output  1  channel 1 accept.
- dout  output  WIDTH  merged data, registered.
- dout_valid  output  1  output word present.
- dout_last  output  1  registered copy of the accepted word's last flag.
- dout_sel  output  1  source channel of current output word (0 or 1).
- dout_ready  input  1  consumer accepts output word.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset state:
  - dout = 0, dout_valid = 0, dout_last = 0, dout_sel = 0.
  - FSM = IDLE; round-robin pointer prefers channel 0.
  - din0_ready = din1_ready = 0 while rst_n is low.
- Output register:
  - One entry.
  - can_load = !dout_valid || dout_ready.
  - A transfer on channel x occurs when dinx_valid && dinx_ready.
  - On a transfer: dout <= dinx, dout_last <= dinx_last, dout_sel <= x, dout_valid <= 1.
  - Otherwise, if dout_ready is high, dout_valid <= 0.
  - Data, last and sel hold while dout_valid && !dout_ready.
- Latency and throughput:
  - Latency is 1 cycle: a word accepted at edge N is visible on dout from edge N.
  - Full throughput is 1 word/cycle with dout_ready held high.
- Grant (combinational from FSM state and valids):
  - IDLE, both valid: grant the pointer channel.
  - IDLE, one valid: grant that channel.
  - IDLE, none valid: no grant.
  - LOCK0: grant channel 0 only. LOCK1: grant channel 1 only.
  - dinx_ready = can_load && (grant == x) && rst_n.
  - The non-granted ready is always 0; at most one ready is high per cycle.
- FSM transitions (only on a transfer):
  - Transfer with last = 0 from IDLE: go to LOCKx (x = granted channel).
  - Transfer with last = 1 in any state: go to IDLE.
  - Transfer in LOCKx with last = 0: stay in LOCKx.
  - No transfer: state holds. A lock persists indefinitely while the locked channel is idle; the other channel waits.
- Pointer:
  - Updated on every transfer with last = 1 from channel x: pointer <= ~x, so the other channel gets preference.
  - Single-word packets (last = 1) therefore alternate when both channels are valid continuously.
- Backpressure: while dout_valid && !dout_ready, both readies are 0 and no state changes.
- Simultaneous drain and load: with dout_ready high and a new transfer in the same cycle, the new word replaces the old with no bubble.
- Reset mid-packet: the FSM returns to IDLE, the output word is dropped (dout_valid = 0), and the pointer is back to channel 0.
- Protocol assumptions on sources: once valid is asserted, the source holds data and last stable until ready. A violating source is not checked.

Test Plan:
- Reset release, din0_valid=1, din0=0x5A, din0_last=1, dout_ready=1 -> din0_ready=1 in that cycle. Next cycle dout=0x5A, dout_sel=0, dout_last=1, dout_valid=1.
- Both valid continuously, last=1, din0=0x11, din1=0x22, dout_ready=1 -> dout sequence 0x11,0x22,0x11,0x22 and dout_sel 0,1,0,1, one word per cycle.
- Channel 1 sends 3-word packet 0xA1,0xA2,0xA3 (last on 0xA3) while din0_valid=1 throughout -> din0_ready=0 for all three cycles; dout order 0xA1,0xA2,0xA3, then channel 0 word; FSM IDLE->LOCK1->IDLE.
- dout_valid=1 with dout=0x33, dout_ready=0 for 4 cycles, both sources valid -> dout holds 0x33, both readies stay 0. On dout_ready=1, the next granted word loads the same cycle with no bubble.
- rst_n pulsed low mid-packet (LOCK0 after 0x01,0x02) -> dout_valid=0 and readies=0 immediately (asynchronous). After release, with both valid, channel 0 is granted first; channel 1 is not blocked by the stale lock.
- Locked on channel 0, din0_valid drops for 3 cycles while din1_valid=1 -> din1_ready stays 0. Channel 0 resumes with last=1, then channel 1 is granted on the following transfer.
